// File: rtl/sdram_init_refresh_if.sv
//------------------------------------------------------------------------------
// Module      : sdram_init_refresh_if
// Description : Bundle of signals between the SDRAM init/refresh sequencer and
//               the SDRAM controller that muxes its command bus.
//               master modport : the sequencer (drives SDRAM command bus,
//                                status and refresh request; takes the grant)
//               slave modport  : the controller side
// Signals     : refresh_gnt     controller idle, bus granted
//               sd_cke          SDRAM clock enable
//               sd_cs_n/ras_n/cas_n/we_n  SDRAM command bits
//               sd_addr[12:0]   SDRAM address
//               sd_ba[1:0]      SDRAM bank address
//               own_bus         sequencer owns the SDRAM command bus
//               ready           init complete (sticky until reset)
//               refresh_req     one or more refreshes pending
//               refresh_overrun sticky: pending counter saturated
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sdram_init_refresh_if;
  logic        refresh_gnt;
  logic        sd_cke;
  logic        sd_cs_n;
  logic        sd_ras_n;
  logic        sd_cas_n;
  logic        sd_we_n;
  logic [12:0] sd_addr;
  logic [1:0]  sd_ba;
  logic        own_bus;
  logic        ready;
  logic        refresh_req;
  logic        refresh_overrun;

  modport master (
    input  refresh_gnt,
    output sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_addr, sd_ba,
    output own_bus, ready, refresh_req, refresh_overrun
  );

  modport slave (
    output refresh_gnt,
    input  sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_addr, sd_ba,
    input  own_bus, ready, refresh_req, refresh_overrun
  );
endinterface

`default_nettype wire

// File: rtl/sdram_init_refresh.sv
//------------------------------------------------------------------------------
// Module      : sdram_init_refresh
// Description : Power-up initialisation and periodic auto-refresh sequencer for
//               an SDR SDRAM. After reset it holds NOP for the power-up wait,
//               then PRECHARGE ALL, INIT_REFS x AUTO REFRESH and LOAD MODE, and
//               raises ready. Afterwards an interval counter queues refreshes
//               (up to 7 pending); each granted refresh is PRECHARGE ALL then
//               AUTO REFRESH with this block owning the command bus.
// Ports       : clk       controller clock, rising edge
//               reset_n   asynchronous active-low reset
//               bus       sdram_init_refresh_if.master (grant in; SDRAM
//                         command bus, own_bus, ready, refresh_req,
//                         refresh_overrun out)
// Config      : SDRAM_FAST_INIT_EN defined -> power-up wait is 16 cycles
//               (simulation); otherwise POWERUP_CYC.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_init_refresh #(
  parameter int          POWERUP_CYC  = 20000,
  parameter int          TRP          = 3,
  parameter int          TRFC         = 7,
  parameter int          TMRD         = 2,
  parameter int          INIT_REFS    = 8,
  parameter int          REF_INTERVAL = 780,
  parameter logic [12:0] MODE_REG     = 13'h022
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  sdram_init_refresh_if.master   bus
);

`ifdef SDRAM_FAST_INIT_EN
  localparam int c_pwr_wait = 16;
`else
  localparam int c_pwr_wait = POWERUP_CYC;
`endif

  // One shared down/up counter covers the power-up wait and all command gaps.
  localparam int c_cnt_top0 = (c_pwr_wait > TRFC) ? c_pwr_wait : TRFC;
  localparam int c_cnt_top1 = (c_cnt_top0 > TRP)  ? c_cnt_top0 : TRP;
  localparam int c_cnt_top  = (c_cnt_top1 > TMRD) ? c_cnt_top1 : TMRD;
  localparam int c_cnt_w    = $clog2(c_cnt_top + 1);
  localparam int c_icnt_w   = ($clog2(REF_INTERVAL) > 10) ? $clog2(REF_INTERVAL) : 10;
  localparam int c_ref_w    = $clog2(INIT_REFS + 1);

  localparam logic [c_cnt_w-1:0]  c_pwr_cnt   = c_cnt_w'(c_pwr_wait);
  localparam logic [c_cnt_w-1:0]  c_trp_ld    = c_cnt_w'(TRP - 1);
  localparam logic [c_cnt_w-1:0]  c_trfc_ld   = c_cnt_w'(TRFC - 1);
  localparam logic [c_cnt_w-1:0]  c_tmrd_ld   = c_cnt_w'(TMRD - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_icnt_w-1:0] c_icnt_last = c_icnt_w'(REF_INTERVAL - 1);
  localparam logic [c_icnt_w-1:0] c_icnt_one  = c_icnt_w'(1);
  localparam logic [c_ref_w-1:0]  c_init_refs = c_ref_w'(INIT_REFS);
  localparam logic [c_ref_w-1:0]  c_ref_one   = c_ref_w'(1);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0]  c_cmd_nop  = 4'b0111;
  localparam logic [3:0]  c_cmd_pre  = 4'b0010;
  localparam logic [3:0]  c_cmd_ref  = 4'b0001;
  localparam logic [3:0]  c_cmd_lmr  = 4'b0000;
  localparam logic [12:0] c_addr_a10 = 13'h0400;

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_INIT_TRP  = 3'd1,
    ST_INIT_TRFC = 3'd2,
    ST_INIT_TMRD = 3'd3,
    ST_IDLE      = 3'd4,
    ST_REF_TRP   = 3'd5,
    ST_REF_TRFC  = 3'd6
  } state_t;

  state_t              state_q,   state_d;
  logic [c_cnt_w-1:0]  cnt_q,     cnt_d;
  logic [c_ref_w-1:0]  ref_cnt_q, ref_cnt_d;
  logic [c_icnt_w-1:0] icnt_q,    icnt_d;
  logic [2:0]          pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                cke_q,     cke_d;
  logic [3:0]          cmd_q,     cmd_d;
  logic [12:0]         addr_q,    addr_d;
  logic                own_bus_q, own_bus_d;
  logic                ready_q,   ready_d;

  logic w_req;
  logic w_tick;
  logic w_accept;

  assign w_req    = (pending_q != 3'd0) && (state_q == ST_IDLE);
  // Interval counter only runs once ready, so the first tick lands
  // REF_INTERVAL cycles after ready rises.
  assign w_tick   = ready_q && (icnt_q == c_icnt_last);
  assign w_accept = w_req && bus.refresh_gnt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_cnt_d = ref_cnt_q;
    cke_d     = 1'b1;
    cmd_d     = c_cmd_nop;
    addr_d    = 13'h0000;
    own_bus_d = own_bus_q;
    ready_d   = ready_q;

    // Interval counter keeps running through refresh sequences.
    if (!ready_q || w_tick) icnt_d = '0;
    else                    icnt_d = icnt_q + c_icnt_one;

    // Tick and accept on the same edge cancel out.
    pending_d = pending_q;
    if (w_tick && !w_accept) begin
      if (pending_q != 3'd7) pending_d = pending_q + 3'd1;
    end else if (w_accept && !w_tick) begin
      pending_d = pending_q - 3'd1;
    end
    overrun_d = overrun_q | (w_tick && (pending_q == 3'd7));

    // Wait states: a command issued at edge e loads T-1, the next command
    // goes out when the counter is found at zero, i.e. at edge e+T.
    case (state_q)
      ST_PWRUP: begin
        own_bus_d = 1'b1;
        if (cnt_q == c_pwr_cnt) begin
          cmd_d   = c_cmd_pre;
          addr_d  = c_addr_a10;
          cnt_d   = c_trp_ld;
          state_d = ST_INIT_TRP;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      ST_INIT_TRP: begin
        if (cnt_q == '0) begin
          cmd_d     = c_cmd_ref;
          cnt_d     = c_trfc_ld;
          ref_cnt_d = c_ref_one;
          state_d   = ST_INIT_TRFC;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      ST_INIT_TRFC: begin
        if (cnt_q == '0) begin
          if (ref_cnt_q == c_init_refs) begin
            cmd_d   = c_cmd_lmr;
            addr_d  = MODE_REG;
            cnt_d   = c_tmrd_ld;
            state_d = ST_INIT_TMRD;
          end else begin
            cmd_d     = c_cmd_ref;
            cnt_d     = c_trfc_ld;
            ref_cnt_d = ref_cnt_q + c_ref_one;
          end
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      ST_INIT_TMRD: begin
        if (cnt_q == '0) begin
          ready_d   = 1'b1;
          own_bus_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          own_bus_d = 1'b1;
          cmd_d     = c_cmd_pre;
          addr_d    = c_addr_a10;
          cnt_d     = c_trp_ld;
          state_d   = ST_REF_TRP;
        end
      end
      ST_REF_TRP: begin
        if (cnt_q == '0) begin
          cmd_d   = c_cmd_ref;
          cnt_d   = c_trfc_ld;
          state_d = ST_REF_TRFC;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      ST_REF_TRFC: begin
        if (cnt_q == '0) begin
          own_bus_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PWRUP;
      cnt_q     <= '0;
      ref_cnt_q <= '0;
      icnt_q    <= '0;
      pending_q <= 3'd0;
      overrun_q <= 1'b0;
      cke_q     <= 1'b0;
      cmd_q     <= c_cmd_nop;
      addr_q    <= 13'h0000;
      own_bus_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_cnt_q <= ref_cnt_d;
      icnt_q    <= icnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      cke_q     <= cke_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      own_bus_q <= own_bus_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.sd_cke          = cke_q;
  assign bus.sd_cs_n         = cmd_q[3];
  assign bus.sd_ras_n        = cmd_q[2];
  assign bus.sd_cas_n        = cmd_q[1];
  assign bus.sd_we_n         = cmd_q[0];
  assign bus.sd_addr         = addr_q;
  assign bus.sd_ba           = 2'b00;
  assign bus.own_bus         = own_bus_q;
  assign bus.ready           = ready_q;
  assign bus.refresh_req     = w_req;
  assign bus.refresh_overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_init_refresh.sv
//------------------------------------------------------------------------------
// Module      : tb_sdram_init_refresh
// Description : Directed self-checking bench for sdram_init_refresh. The
//               power-up wait is overridden to 16 cycles so the timeline
//               matches the fast-init schedule whether or not
//               SDRAM_FAST_INIT_EN is defined. Cycle 0 is the first rising
//               edge after reset_n rises; outputs are sampled on falling edges.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sdram_init_refresh;

  localparam logic [3:0]  C_NOP = 4'b0111;
  localparam logic [3:0]  C_PRE = 4'b0010;
  localparam logic [3:0]  C_REF = 4'b0001;
  localparam logic [3:0]  C_LMR = 4'b0000;
  localparam logic [12:0] C_A10 = 13'h0400;
  localparam logic [12:0] C_MRS = 13'h0022;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   failures;

  sdram_init_refresh_if bus_if ();

  sdram_init_refresh #(
    .POWERUP_CYC (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cke, cmd, addr, ba, own_bus, ready, refresh_req, refresh_overrun}
  function automatic logic [23:0] mon();
    return {bus_if.sd_cke, bus_if.sd_cs_n, bus_if.sd_ras_n, bus_if.sd_cas_n,
            bus_if.sd_we_n, bus_if.sd_addr, bus_if.sd_ba, bus_if.own_bus,
            bus_if.ready, bus_if.refresh_req, bus_if.refresh_overrun};
  endfunction

  function automatic logic [23:0] exp_vec(input logic [3:0] c, input logic [12:0] a,
                                          input logic own, input logic rdy,
                                          input logic req, input logic ovr);
    return {1'b1, c, a, 2'b00, own, rdy, req, ovr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Reset release happens on a falling edge; the next rising edge is cycle 0.
  task automatic check_init();
    for (int i = 0; i <= 77; i++) begin
      logic [3:0]  ec;
      logic [12:0] ea;
      step();
      ec = C_NOP;
      ea = 13'h0;
      if (cyc == 16) begin
        ec = C_PRE;
        ea = C_A10;
      end else if (cyc >= 19 && cyc <= 68 && ((cyc - 19) % 7) == 0) begin
        ec = C_REF;
      end else if (cyc == 75) begin
        ec = C_LMR;
        ea = C_MRS;
      end
      chk("init", 32'(mon()), 32'(exp_vec(ec, ea, cyc < 77, cyc >= 77, 1'b0, 1'b0)));
    end
  endtask

  // Call with refresh_req=1 and refresh_gnt=1 already driven; covers the 11
  // cycles from PRECHARGE (accept edge) to the return to IDLE.
  task automatic check_seq(input logic hold, input logic req_end, input logic ovr);
    for (int i = 0; i <= 10; i++) begin
      logic [3:0]  ec;
      logic [12:0] ea;
      step();
      if (i == 0 && !hold) bus_if.refresh_gnt = 1'b0;
      ec = (i == 0) ? C_PRE : ((i == 3) ? C_REF : C_NOP);
      ea = (i == 0) ? C_A10 : 13'h0;
      chk("refresh_seq", 32'(mon()),
          32'(exp_vec(ec, ea, i < 10, 1'b1, (i == 10) ? req_end : 1'b0, ovr)));
    end
  endtask

  // Idle stretch: bus released, only NOPs.
  task automatic wait_to(input int n);
    while (cyc < n) begin
      step();
      chk("idle_bus", {26'd0, bus_if.sd_cs_n, bus_if.sd_ras_n, bus_if.sd_cas_n,
                       bus_if.sd_we_n, bus_if.own_bus, bus_if.ready},
          {26'd0, C_NOP, 2'b01});
    end
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog cyc=%0d observed=timeout required=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = -1;
    reset_n  = 1'b0;
    bus_if.refresh_gnt = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(mon()), {8'd0, 1'b0, C_NOP, 13'h0, 2'b00, 4'b1000});
    reset_n = 1'b1;
    cyc = -1;

    // Test 1: init sequence
    check_init();

    // Test 2: first refresh request 780 cycles after ready, single-cycle grant
    wait_to(856);
    chk("req_before_tick", 32'(bus_if.refresh_req), 32'd0);
    step();
    chk("req_at_tick", 32'(bus_if.refresh_req), 32'd1);
    bus_if.refresh_gnt = 1'b1;
    check_seq(1'b0, 1'b0, 1'b0);

    // Test 3: backlog of 3 refreshes, grant held high
    wait_to(1637);
    chk("req_tick2", 32'(bus_if.refresh_req), 32'd1);
    wait_to(3197);
    bus_if.refresh_gnt = 1'b1;
    check_seq(1'b1, 1'b1, 1'b0);
    check_seq(1'b1, 1'b1, 1'b0);
    check_seq(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gnt_ignored", 32'(mon()), 32'(exp_vec(C_NOP, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0)));
    end
    bus_if.refresh_gnt = 1'b0;

    // Test 4: overrun after 8 withheld intervals, pending saturates at 7
    wait_to(3977);
    chk("req_tick4", 32'(bus_if.refresh_req), 32'd1);
    wait_to(9436);
    chk("overrun_before", 32'(bus_if.refresh_overrun), 32'd0);
    step();
    chk("overrun_at_8th", 32'(bus_if.refresh_overrun), 32'd1);
    bus_if.refresh_gnt = 1'b1;
    for (int k = 0; k < 6; k++) check_seq(1'b1, 1'b1, 1'b1);
    check_seq(1'b1, 1'b0, 1'b1);
    bus_if.refresh_gnt = 1'b0;
    wait_to(9520);
    chk("overrun_sticky", 32'(bus_if.refresh_overrun), 32'd1);

    // Test 5: grant accepted on the same edge as a tick with pending=1
    wait_to(10216);
    chk("req_before_tick5", 32'(bus_if.refresh_req), 32'd0);
    step();
    chk("req_tick5", 32'(bus_if.refresh_req), 32'd1);
    wait_to(10996);
    bus_if.refresh_gnt = 1'b1;
    check_seq(1'b0, 1'b1, 1'b1);
    bus_if.refresh_gnt = 1'b1;
    check_seq(1'b0, 1'b0, 1'b1);

    // Test 6: asynchronous reset during the REFRESH wait, init replays
    wait_to(11776);
    step();
    chk("req_tick6", 32'(bus_if.refresh_req), 32'd1);
    bus_if.refresh_gnt = 1'b1;
    step();
    bus_if.refresh_gnt = 1'b0;
    chk("pre_before_reset", {28'd0, bus_if.sd_cs_n, bus_if.sd_ras_n, bus_if.sd_cas_n,
                             bus_if.sd_we_n}, {28'd0, C_PRE});
    repeat (3) step();
    chk("ref_before_reset", {28'd0, bus_if.sd_cs_n, bus_if.sd_ras_n, bus_if.sd_cas_n,
                             bus_if.sd_we_n}, {28'd0, C_REF});
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 32'(mon()), {8'd0, 1'b0, C_NOP, 13'h0, 2'b00, 4'b1000});
    repeat (2) @(negedge clk);
    chk("reset_held", 32'(mon()), {8'd0, 1'b0, C_NOP, 13'h0, 2'b00, 4'b1000});
    reset_n = 1'b1;
    cyc = -1;
    check_init();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
